// File: rtl/dma_pkg.sv
// Shared state encoding and AXI constants for the EPU DMA master.
// Fallback AXI widths for builds that do not provide the system-wide defines.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WDATA = 3'd4,
    ST_WRESP = 3'd5,
    ST_DONE  = 3'd6
  } dma_state_e;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] WSTRB_ALL  = 4'hF;

endpackage

// File: rtl/dma_burst_buf.sv
// Burst staging buffer: one write port fed by R beats, one combinational read port feeding W.
module dma_burst_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Capture one accepted read beat per cycle.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/epu_dma_master.sv
// AXI4 block-copy master: reads bursts of up to BUF_DEPTH words, then writes them back out.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

module epu_dma_master
  import dma_pkg::*;
#(
  parameter int                      BUF_DEPTH   = 16,
  parameter int                      MAX_WORDS_W = 16,
  parameter logic [`AXI_ID_BITS-1:0] DMA_ID      = 4'd2
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        cfg_start,
  input  logic [`AXI_ADDR_BITS-1:0]   cfg_src,
  input  logic [`AXI_ADDR_BITS-1:0]   cfg_dst,
  input  logic [MAX_WORDS_W-1:0]      cfg_words,
  input  logic                        cfg_clr,
  output logic                        dma_busy,
  output logic                        dma_err,
  output logic                        dma_interrupt,
  output logic [`AXI_ID_BITS-1:0]     ARID,
  output logic [`AXI_ADDR_BITS-1:0]   ARADDR,
  output logic [`AXI_LEN_BITS-1:0]    ARLEN,
  output logic [2:0]                  ARSIZE,
  output logic [1:0]                  ARBURST,
  output logic                        ARVALID,
  input  logic                        ARREADY,
  input  logic [`AXI_ID_BITS-1:0]     RID,
  input  logic [`AXI_DATA_BITS-1:0]   RDATA,
  input  logic [1:0]                  RRESP,
  input  logic                        RLAST,
  input  logic                        RVALID,
  output logic                        RREADY,
  output logic [`AXI_ID_BITS-1:0]     AWID,
  output logic [`AXI_ADDR_BITS-1:0]   AWADDR,
  output logic [`AXI_LEN_BITS-1:0]    AWLEN,
  output logic [2:0]                  AWSIZE,
  output logic [1:0]                  AWBURST,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [`AXI_DATA_BITS-1:0]   WDATA,
  output logic [`AXI_DATA_BITS/8-1:0] WSTRB,
  output logic                        WLAST,
  output logic                        WVALID,
  input  logic                        WREADY,
  input  logic [`AXI_ID_BITS-1:0]     BID,
  input  logic [1:0]                  BRESP,
  input  logic                        BVALID,
  output logic                        BREADY
);

  localparam int ADDR_W = `AXI_ADDR_BITS;
  localparam int LEN_W  = `AXI_LEN_BITS;
  localparam int IDX_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = IDX_W + 1;

  dma_state_e             state_r;
  logic [ADDR_W-1:0]      src_r;
  logic [ADDR_W-1:0]      dst_r;
  logic [MAX_WORDS_W-1:0] rem_r;
  logic [CNT_W-1:0]       blen_r;
  logic [IDX_W-1:0]       rcnt_r;
  logic [IDX_W-1:0]       wcnt_r;
  logic                   err_pend_r;

  logic [MAX_WORDS_W-1:0] rem_next_s;
  logic [CNT_W-1:0]       blen_next_s;
  logic [IDX_W-1:0]       last_idx_s;
  logic [ADDR_W-1:0]      step_s;
  logic                   rd_fire_s;
  logic                   rd_last_s;
  logic                   wr_last_s;
  logic                   unused_ok_s;

  assign ARID    = DMA_ID;
  assign AWID    = DMA_ID;
  assign ARSIZE  = SIZE_WORD;
  assign AWSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;
  assign AWBURST = BURST_INCR;
  assign WSTRB   = WSTRB_ALL;

  assign last_idx_s = IDX_W'(blen_r - CNT_W'(1));
  assign step_s     = ADDR_W'({blen_r, 2'b00});
  assign rd_fire_s  = (state_r == ST_RDATA) && RVALID && RREADY;
  assign rd_last_s  = (rcnt_r == last_idx_s);
  assign wr_last_s  = (wcnt_r == last_idx_s);
  assign unused_ok_s = ^{RID, BID};

  // Words left after the current burst and the size of the burst that follows.
  always_comb begin
    rem_next_s  = '0;
    blen_next_s = '0;
    if (state_r == ST_IDLE) begin
      rem_next_s = cfg_words;
    end else begin
      rem_next_s = rem_r - MAX_WORDS_W'(blen_r);
    end
    if (rem_next_s >= MAX_WORDS_W'(BUF_DEPTH)) begin
      blen_next_s = CNT_W'(BUF_DEPTH);
    end else begin
      blen_next_s = rem_next_s[CNT_W-1:0];
    end
  end

  dma_burst_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (`AXI_DATA_BITS)
  ) u_buf (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .wr_en   (rd_fire_s),
    .wr_idx  (rcnt_r),
    .wr_data (RDATA),
    .rd_idx  (wcnt_r),
    .rd_data (WDATA)
  );

  // Transfer sequencer with all handshake and status outputs registered.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r       <= ST_IDLE;
      src_r         <= '0;
      dst_r         <= '0;
      rem_r         <= '0;
      blen_r        <= '0;
      rcnt_r        <= '0;
      wcnt_r        <= '0;
      err_pend_r    <= 1'b0;
      ARADDR        <= '0;
      ARLEN         <= '0;
      ARVALID       <= 1'b0;
      RREADY        <= 1'b0;
      AWADDR        <= '0;
      AWLEN         <= '0;
      AWVALID       <= 1'b0;
      WVALID        <= 1'b0;
      WLAST         <= 1'b0;
      BREADY        <= 1'b0;
      dma_busy      <= 1'b0;
      dma_err       <= 1'b0;
      dma_interrupt <= 1'b0;
    end else begin
      if (cfg_clr) begin
        dma_interrupt <= 1'b0;
        dma_err       <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            src_r      <= cfg_src;
            dst_r      <= cfg_dst;
            rem_r      <= cfg_words;
            blen_r     <= blen_next_s;
            rcnt_r     <= '0;
            wcnt_r     <= '0;
            err_pend_r <= 1'b0;
            if (cfg_words == '0) begin
              state_r <= ST_DONE;
            end else begin
              state_r  <= ST_RADDR;
              dma_busy <= 1'b1;
              ARVALID  <= 1'b1;
              ARADDR   <= cfg_src;
              ARLEN    <= LEN_W'(blen_next_s - CNT_W'(1));
            end
          end
        end
        ST_RADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            rcnt_r  <= '0;
            state_r <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (rd_fire_s) begin
            // The beat count, not RLAST, ends the burst; a disagreeing RLAST is flagged.
            if ((RRESP != RESP_OKAY) || (RLAST != rd_last_s)) begin
              err_pend_r <= 1'b1;
            end
            if (rd_last_s) begin
              RREADY  <= 1'b0;
              AWVALID <= 1'b1;
              AWADDR  <= dst_r;
              AWLEN   <= LEN_W'(last_idx_s);
              state_r <= ST_WADDR;
            end else begin
              rcnt_r <= rcnt_r + IDX_W'(1);
            end
          end
        end
        ST_WADDR: begin
          if (AWREADY) begin
            AWVALID <= 1'b0;
            WVALID  <= 1'b1;
            WLAST   <= (blen_r == CNT_W'(1));
            wcnt_r  <= '0;
            state_r <= ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (WREADY) begin
            if (wr_last_s) begin
              WVALID  <= 1'b0;
              WLAST   <= 1'b0;
              BREADY  <= 1'b1;
              state_r <= ST_WRESP;
            end else begin
              wcnt_r <= wcnt_r + IDX_W'(1);
              WLAST  <= ((wcnt_r + IDX_W'(1)) == last_idx_s);
            end
          end
        end
        ST_WRESP: begin
          if (BVALID) begin
            BREADY <= 1'b0;
            src_r  <= src_r + step_s;
            dst_r  <= dst_r + step_s;
            rem_r  <= rem_next_s;
            if (BRESP != RESP_OKAY) begin
              err_pend_r <= 1'b1;
            end
            if ((rem_next_s == '0) || err_pend_r || (BRESP != RESP_OKAY)) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_RADDR;
              blen_r  <= blen_next_s;
              ARVALID <= 1'b1;
              ARADDR  <= src_r + step_s;
              ARLEN   <= LEN_W'(blen_next_s - CNT_W'(1));
            end
          end
        end
        ST_DONE: begin
          // Setting the status takes priority over a coincident clear.
          dma_interrupt <= 1'b1;
          dma_err       <= (dma_err & ~cfg_clr) | err_pend_r;
          dma_busy      <= 1'b0;
          state_r       <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_epu_dma_master.sv
// Self-checking bench: AXI slave model with a data scoreboard, a vector table and corner sequences.
module tb_epu_dma_master;

  logic        ACLK;
  logic        ARESETn;
  logic        cfg_start;
  logic [31:0] cfg_src;
  logic [31:0] cfg_dst;
  logic [15:0] cfg_words;
  logic        cfg_clr;
  logic        dma_busy, dma_err, dma_interrupt;
  logic [3:0]  ARID, AWID, RID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [3:0]  ARLEN, AWLEN, WSTRB;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  epu_dma_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .cfg_start(cfg_start), .cfg_src(cfg_src),
    .cfg_dst(cfg_dst), .cfg_words(cfg_words), .cfg_clr(cfg_clr), .dma_busy(dma_busy),
    .dma_err(dma_err), .dma_interrupt(dma_interrupt),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
  } burst_t;

  typedef struct {
    int          words;
    logic [31:0] src;
    logic [31:0] dst;
    bit          stall;
    int          eburst;
  } vec_t;

  int total = 0;
  int bad   = 0;

  burst_t      ar_q[$];
  burst_t      aw_q[$];
  logic [31:0] exp_q[$];

  bit          stall_en = 1'b0;
  int          err_burst = -1;
  logic [31:0] cur_src = '0;
  int          r_left = 0, w_left = 0, burst_no = 0;
  int          r_cnt = 0, w_cnt = 0, ar_cnt = 0, done_cnt = 0;
  logic [31:0] r_addr = '0;
  bit          b_pend = 1'b0, r_hs = 1'b0, b_hs = 1'b0, intr_prev = 1'b0;
  bit          ar_wait = 1'b0, aw_wait = 1'b0, w_wait = 1'b0;
  logic [31:0] ar_hold = '0, aw_hold = '0, wd_hold = '0;
  bit          wl_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit go();
    if (!stall_en) return 1'b1;
    return ($urandom_range(0, 2) == 0);
  endfunction

  // AXI slave model: drives at negedge, a handshake seen here completes at the next posedge.
  initial begin : slave
    burst_t bd;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RID = 4'd2;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; BID = 4'd2;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
        r_left = 0; w_left = 0; b_pend = 1'b0; r_hs = 1'b0; b_hs = 1'b0;
        ar_wait = 1'b0; aw_wait = 1'b0; w_wait = 1'b0;
        ar_q.delete(); aw_q.delete(); exp_q.delete();
      end else begin
        if (dma_interrupt && !intr_prev) done_cnt++;
        // R channel: a driven beat is the stimulus whose data is expected back on W
        if (r_hs) begin RVALID = 1'b0; RLAST = 1'b0; end
        r_hs = 1'b0;
        if (!RVALID && r_left > 0 && go()) begin
          RVALID = 1'b1;
          RDATA  = 32'hA500_0000 + ((r_addr - cur_src) >> 2);
          RLAST  = (r_left == 1);
          RRESP  = 2'b00;
        end
        if (RVALID && RREADY) begin
          r_hs = 1'b1; exp_q.push_back(RDATA); r_left--; r_addr += 32'd4; r_cnt++;
        end
        // AR channel
        if (ar_wait) begin
          check("arvalid_hold", 32'(ARVALID), 32'd1);
          check("araddr_hold", ARADDR, ar_hold);
        end
        ARREADY = go();
        if (ARVALID && ARREADY) begin
          ar_wait = 1'b0; ar_cnt++;
          check("ar_expected", 32'(ar_q.size() != 0), 32'd1);
          if (ar_q.size() != 0) begin
            bd = ar_q.pop_front();
            check("araddr", ARADDR, bd.addr);
            check("arlen", 32'(ARLEN), 32'(bd.len));
          end
          r_left = int'(ARLEN) + 1; r_addr = ARADDR;
        end else begin
          ar_wait = ARVALID; ar_hold = ARADDR;
        end
        // B channel
        if (b_hs) BVALID = 1'b0;
        b_hs = 1'b0;
        if (!BVALID && b_pend && go()) begin
          BVALID = 1'b1; BRESP = (burst_no == err_burst) ? 2'b10 : 2'b00; b_pend = 1'b0;
        end
        if (BVALID && BREADY) begin b_hs = 1'b1; burst_no++; end
        // W channel: pop scoreboard
        if (w_wait) begin
          check("wvalid_hold", 32'(WVALID), 32'd1);
          check("wdata_hold", WDATA, wd_hold);
          check("wlast_hold", 32'(WLAST), 32'(wl_hold));
        end
        WREADY = go();
        if (WVALID && WREADY) begin
          w_wait = 1'b0;
          check("w_after_aw", 32'(w_left > 0), 32'd1);
          check("w_sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("wdata_sb", WDATA, exp_q.pop_front());
          check("wdata_order", WDATA, 32'hA500_0000 + 32'(w_cnt));
          check("wlast", 32'(WLAST), 32'(w_left == 1));
          check("wstrb", 32'(WSTRB), 32'hF);
          w_left--; w_cnt++;
          if (w_left == 0) b_pend = 1'b1;
        end else begin
          w_wait = WVALID; wd_hold = WDATA; wl_hold = WLAST;
        end
        // AW channel
        if (aw_wait) begin
          check("awvalid_hold", 32'(AWVALID), 32'd1);
          check("awaddr_hold", AWADDR, aw_hold);
        end
        AWREADY = go();
        if (AWVALID && AWREADY) begin
          aw_wait = 1'b0;
          check("aw_expected", 32'(aw_q.size() != 0), 32'd1);
          if (aw_q.size() != 0) begin
            bd = aw_q.pop_front();
            check("awaddr", AWADDR, bd.addr);
            check("awlen", 32'(AWLEN), 32'(bd.len));
          end
          w_left = int'(AWLEN) + 1;
        end else begin
          aw_wait = AWVALID; aw_hold = AWADDR;
        end
      end
      intr_prev = dma_interrupt;
    end
  end

  task automatic start_xfer(input int words, input logic [31:0] src, input logic [31:0] dst,
                            input bit stall, input int eburst,
                            output int eb, output int nb, output bit ee);
    int rem;
    logic [31:0] a, d;
    burst_t bd;
    int bl;
    rem = words; a = src; d = dst; eb = 0; nb = 0; ee = 1'b0;
    while (rem > 0) begin
      bl = (rem > 16) ? 16 : rem;
      bd.addr = a; bd.len = 4'(bl - 1); ar_q.push_back(bd);
      bd.addr = d; aw_q.push_back(bd);
      eb += bl;
      if (nb == eburst) begin ee = 1'b1; nb++; break; end
      nb++; a += 32'(4 * bl); d += 32'(4 * bl); rem -= bl;
    end
    cur_src = src; stall_en = stall; err_burst = eburst;
    burst_no = 0; w_cnt = 0; r_cnt = 0; ar_cnt = 0; done_cnt = 0;
    @(negedge ACLK);
    cfg_src = src; cfg_dst = dst; cfg_words = 16'(words); cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge ACLK);
      seen = dma_interrupt;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic finish_checks(input string tag, input bit ee, input int eb, input int nb);
    repeat (8) @(negedge ACLK);
    check({tag, "_intr"}, 32'(dma_interrupt), 32'd1);
    check({tag, "_err"}, 32'(dma_err), 32'(ee));
    check({tag, "_busy"}, 32'(dma_busy), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_ar_cnt"}, 32'(ar_cnt), 32'(nb));
    check({tag, "_w_beats"}, 32'(w_cnt), 32'(eb));
    check({tag, "_ar_left"}, 32'(ar_q.size()), 32'd0);
    check({tag, "_aw_left"}, 32'(aw_q.size()), 32'd0);
    check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    cfg_clr = 1'b1;
    @(negedge ACLK);
    cfg_clr = 1'b0;
    check({tag, "_clr_intr"}, 32'(dma_interrupt), 32'd0);
    check({tag, "_clr_err"}, 32'(dma_err), 32'd0);
  endtask

  // Test sequencer.
  initial begin : main
    vec_t vecs[6];
    int   eb, nb;
    bit   ee, seen;
    string tag;
    ARESETn = 1'b0; cfg_start = 1'b0; cfg_clr = 1'b0;
    cfg_src = '0; cfg_dst = '0; cfg_words = '0;
    vecs[0] = '{1,  32'h0001_0000, 32'h0003_0000, 1'b0, -1};
    vecs[1] = '{20, 32'h0001_0000, 32'h0003_0000, 1'b0, -1};
    vecs[2] = '{16, 32'h0002_0000, 32'h0004_0000, 1'b1, -1};
    vecs[3] = '{32, 32'h0005_0000, 32'h0005_8000, 1'b0, 0};
    vecs[4] = '{37, 32'h0000_0100, 32'h0000_2000, 1'b1, -1};
    vecs[5] = '{48, 32'h0001_0000, 32'h0002_0000, 1'b1, 1};

    repeat (3) @(negedge ACLK);
    check("rst_handshakes", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 32'd0);
    check("rst_status", 32'({dma_busy, dma_err, dma_interrupt}), 32'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("idle_araddr", ARADDR, 32'd0);
    check("idle_awaddr", AWADDR, 32'd0);
    check("idle_lens", 32'({ARLEN, AWLEN}), 32'd0);
    check("idle_size", 32'({ARSIZE, AWSIZE}), 32'h12);
    check("idle_burst", 32'({ARBURST, AWBURST}), 32'h5);
    check("idle_ids", 32'({ARID, AWID}), 32'h22);
    check("idle_handshakes", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY, dma_busy}), 32'd0);

    for (int v = 0; v < 6; v++) begin
      tag = $sformatf("vec%0d", v);
      start_xfer(vecs[v].words, vecs[v].src, vecs[v].dst, vecs[v].stall, vecs[v].eburst, eb, nb, ee);
      wait_done(tag);
      finish_checks(tag, ee, eb, nb);
    end

    // Zero-length transfer completes without bus traffic.
    start_xfer(0, 32'h0001_0000, 32'h0003_0000, 1'b0, -1, eb, nb, ee);
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge ACLK);
      seen = dma_interrupt;
    end
    check("zero_intr_2cyc", 32'(seen), 32'd1);
    finish_checks("zero", 1'b0, 0, 0);

    // A start while busy must not disturb the running transfer.
    start_xfer(20, 32'h0006_0000, 32'h0007_0000, 1'b1, -1, eb, nb, ee);
    repeat (6) @(negedge ACLK);
    check("busy_mid", 32'(dma_busy), 32'd1);
    cfg_src = 32'hDEAD_0000; cfg_dst = 32'hBEEF_0000; cfg_words = 16'd7; cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    wait_done("busy_start");
    finish_checks("busy_start", ee, eb, nb);

    // Asynchronous reset in the middle of a read burst.
    start_xfer(16, 32'h0009_0000, 32'h000A_0000, 1'b0, -1, eb, nb, ee);
    for (int i = 0; i < 200 && r_cnt < 5; i++) @(negedge ACLK);
    check("rst_reach_beat5", 32'(r_cnt >= 5), 32'd1);
    #2;
    ARESETn = 1'b0;
    #1;
    check("arst_handshakes", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 32'd0);
    check("arst_status", 32'({dma_busy, dma_interrupt, dma_err}), 32'd0);
    check("arst_araddr", ARADDR, 32'd0);
    repeat (3) @(negedge ACLK);
    #2;
    ARESETn = 1'b1;
    start_xfer(3, 32'h000B_0000, 32'h000C_0000, 1'b0, -1, eb, nb, ee);
    wait_done("post_rst");
    finish_checks("post_rst", ee, eb, nb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/epu_dma_master.md
Name: epu_dma_master

Overview:
- AXI4 master (initiator) that moves a block of 32-bit words from a source address to a destination address.
- Typical use: fill EPU Image0/Weight/Image1 SRAM from DRAM, or drain results back, without CPU load/store loops.
- Sits on the system bus as an additional master next to the CPU. It drives the same AR/R/AW/W/B protocol that the EPU wrapper answers as a slave.
- Programmed by a simple register-side interface from a small CSR slave.

Parameters:
- BUF_DEPTH, 16, beats buffered per burst; also the maximum AxLEN+1.
- MAX_WORDS_W, 16, width of the transfer word count.
- DMA_ID, 4'd2, constant ARID/AWID driven by this master.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle start pulse; ignored unless idle
- cfg_src  in  32  source byte address, word aligned
- cfg_dst  in  32  destination byte address, word aligned
- cfg_words  in  MAX_WORDS_W  number of words; 0 = complete immediately
- cfg_clr  in  1  clears dma_interrupt and dma_err
- dma_busy  out  1  high from accepted start until DONE
- dma_err  out  1  sticky; set on any RRESP/BRESP != OKAY
- dma_interrupt  out  1  level; set in DONE, held until cfg_clr
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  4/32/4/3/2  read address
- ARVALID out 1; ARREADY in 1  read address handshake
- RID/RDATA/RRESP/RLAST/RVALID  in  4/32/2/1/1  read data
- RREADY  out  1
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  4/32/4/3/2  write address
- AWVALID out 1; AWREADY in 1  write address handshake
- WDATA/WSTRB/WLAST/WVALID  out  32/4/1/1  write data
- WREADY  in  1
- BID/BRESP/BVALID  in  4/2/1  write response
- BREADY  out  1

Behaviour:
- Reset: state IDLE. All VALID/READY outputs, dma_busy, dma_err and dma_interrupt are 0. Address/length outputs are 0. ARSIZE=AWSIZE=3'b010, ARBURST=AWBURST=INCR constantly.
- FSM states: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE.
- IDLE: on cfg_start, latch src/dst/remaining=cfg_words.
  - remaining==0 -> DONE.
  - otherwise -> RADDR; dma_busy=1 on the next cycle.
- Burst length: blen = min(remaining, BUF_DEPTH); ARLEN=AWLEN=blen-1. Software guarantees no burst crosses a 4KB boundary; the block does not split.
- RADDR: ARVALID=1 with ARADDR=src. ARVALID and ARADDR stay stable until ARREADY. On handshake -> RDATA.
- RDATA: RREADY=1. Each RVALID&RREADY beat writes RDATA into buf[rcnt] and increments rcnt.
  - Any RRESP!=0 sets err_pending.
  - On the beat with rcnt==blen-1 -> WADDR, regardless of RLAST; an RLAST mismatch also sets err_pending.
- WADDR: AWVALID=1 with AWADDR=dst, held stable until AWREADY -> WDATA. AW is issued before any W beat.
- WDATA: WVALID=1, WDATA=buf[wcnt], WSTRB=4'hF, WLAST=(wcnt==blen-1).
  - WDATA/WLAST are held stable while WREADY=0.
  - Increment wcnt on handshake; after the last beat -> WRESP.
- WRESP: BREADY=1. On BVALID:
  - BRESP!=0 sets err_pending.
  - src+=4*blen, dst+=4*blen, remaining-=blen.
  - If remaining==0 or err_pending -> DONE; else -> RADDR.
- Error abort: an error never cuts a burst short. The current read burst, write burst and response always complete before abort.
- DONE: single cycle. dma_interrupt<=1, dma_err<=dma_err|err_pending, dma_busy<=0 -> IDLE.
- cfg_clr clears dma_interrupt and dma_err. If it coincides with DONE, set wins.
- cfg_start while busy is ignored, and the latched configuration is unchanged.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous). An in-flight burst is abandoned, and the slave is also reset.
- Buffer: flop array BUF_DEPTH x 32. No read-before-write hazard, because R and W phases never overlap.
- Latency: zero-wait slaves give 1 cycle AR + blen cycles R + 1 AW + blen W + 1 B per burst.

Decomposition:
- Shared package dma_pkg holds:
  - state enum dma_state_e
  - AXI constants SIZE_WORD=3'b010, BURST_INCR=2'b01, RESP_OKAY=2'b00
- Existing AXI width macros (AXI_ADDR_BITS, AXI_DATA_BITS, AXI_LEN_BITS, AXI_ID_BITS) are used for port widths.
- One sub-module, dma_burst_buf: synchronous-write, combinational-read register file with wr_en/wr_idx/wr_data and rd_idx/rd_data.

Test Plan:
- cfg_words=1, src=0x0001_0000, dst=0x0003_0000, zero-wait slave -> ARLEN=0, AWLEN=0; WDATA equals the read word; WLAST on beat 0; dma_interrupt=1, dma_err=0.
- cfg_words=20 -> burst 1 has ARLEN=15 at src; burst 2 has ARLEN=3 at src+0x40 and AWADDR=dst+0x40; 20 W beats in read order; exactly one DONE.
- Random ARREADY/RVALID/AWREADY/WREADY stalls, 0-5 cycles, cfg_words=16 -> ARADDR/AWADDR/WDATA/WLAST stable while stalled; data matches the source pattern 0xA5000000+i.
- BRESP=2'b10 on burst 1 of cfg_words=32 -> no second AR issued; dma_err=1, dma_interrupt=1; cfg_clr clears both next cycle.
- cfg_start while busy with a different cfg_src -> ignored; the transfer finishes with the original addresses. cfg_words=0 -> dma_interrupt within 2 cycles and no AXI traffic.
- ARESETn low during RDATA beat 5 -> all VALID/READY outputs 0 immediately; after release, a new cfg_start completes normally.
